// File: rtl/qdma_c2h_st_pkt_gen.sv
// C2H streaming packet source: NUM packets of LEN bytes on one queue,
// deterministic byte pattern, one completion entry per packet.
module qdma_c2h_st_pkt_gen #(
    parameter int DATA_W = 512,
    parameter int LEN_W  = 16,
    parameter int QID_W  = 12,
    parameter int CNT_W  = 16,
    parameter int CMPT_W = 128
) (
    input  logic                          axi_aclk,
    input  logic                          axi_aresetn,
    input  logic                          start,
    input  logic                          stop,
    input  logic [QID_W-1:0]              cfg_qid,
    input  logic [LEN_W-1:0]              cfg_len,
    input  logic [CNT_W-1:0]              cfg_num,
    output logic [DATA_W-1:0]             c2h_tdata,
    output logic                          c2h_tvalid,
    input  logic                          c2h_tready,
    output logic                          c2h_tlast,
    output logic [$clog2(DATA_W/8)-1:0]   c2h_mty,
    output logic [LEN_W-1:0]              c2h_ctrl_len,
    output logic [QID_W-1:0]              c2h_ctrl_qid,
    output logic [CMPT_W-1:0]             cmpt_tdata,
    output logic                          cmpt_tvalid,
    input  logic                          cmpt_tready,
    output logic                          busy,
    output logic                          done,
    output logic                          cfg_err,
    output logic [CNT_W-1:0]              pkt_sent
);
    localparam int BYTES = DATA_W / 8;
    localparam int MTY_W = $clog2(BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CMPT} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [QID_W-1:0]   r_qid;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_num;
    logic [CNT_W-1:0]   r_pkt_idx;
    logic [CNT_W-1:0]   r_pkt_sent;
    logic [LEN_W-1:0]   r_beat;
    logic [LEN_W-1:0]   r_last_beat;
    logic               r_done;
    logic               r_cfg_err;

    logic               w_start_ok;
    logic               w_start_bad;
    logic               w_last;
    logic               w_c2h_hs;
    logic               w_cmpt_hs;
    logic               w_run_end;
    logic [CNT_W-1:0]   w_pkt_next;
    logic [MTY_W-1:0]   w_mty_last;
    logic [7:0]         w_base;

    assign w_start_ok  = (r_state == S_IDLE) && start &&
                         (cfg_len != '0) && (cfg_num != '0);
    assign w_start_bad = (r_state == S_IDLE) && start &&
                         ((cfg_len == '0) || (cfg_num == '0));
    assign w_last      = (r_beat == r_last_beat);
    assign w_c2h_hs    = (r_state == S_DATA) && c2h_tready;
    assign w_cmpt_hs   = (r_state == S_CMPT) && cmpt_tready;
    assign w_pkt_next  = r_pkt_idx + 1'b1;
    assign w_run_end   = w_cmpt_hs && ((w_pkt_next == r_num) || stop);
    // Empty bytes on the last beat: (-len) mod BYTES.
    assign w_mty_last  = -r_len[MTY_W-1:0];
    assign w_base      = r_pkt_idx[7:0] + 8'({r_beat, MTY_W'(0)});

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) r_state <= S_IDLE;
        else              r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_start_ok) w_next = S_DATA;
            S_DATA:  if (w_c2h_hs && w_last) w_next = S_CMPT;
            S_CMPT:  if (w_cmpt_hs) w_next = w_run_end ? S_IDLE : S_DATA;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            r_qid       <= '0;
            r_len       <= '0;
            r_num       <= '0;
            r_pkt_idx   <= '0;
            r_pkt_sent  <= '0;
            r_beat      <= '0;
            r_last_beat <= '0;
            r_done      <= 1'b0;
            r_cfg_err   <= 1'b0;
        end else begin
            r_done    <= w_run_end;
            r_cfg_err <= w_start_bad;
            if (w_start_ok) begin
                r_qid       <= cfg_qid;
                r_len       <= cfg_len;
                r_num       <= cfg_num;
                r_last_beat <= (cfg_len - 1'b1) >> MTY_W;
                r_beat      <= '0;
                r_pkt_idx   <= '0;
                r_pkt_sent  <= '0;
            end
            if (w_c2h_hs) r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_cmpt_hs) begin
                r_pkt_idx  <= w_pkt_next;
                r_pkt_sent <= r_pkt_sent + 1'b1;
            end
        end
    end

    // Payload and sideband are forced to zero outside their own state.
    always_comb begin
        c2h_tdata    = '0;
        c2h_tvalid   = 1'b0;
        c2h_tlast    = 1'b0;
        c2h_mty      = '0;
        c2h_ctrl_len = '0;
        c2h_ctrl_qid = '0;
        cmpt_tdata   = '0;
        cmpt_tvalid  = 1'b0;
        if (r_state == S_DATA) begin
            for (int i = 0; i < BYTES; i++) begin
                c2h_tdata[8*i +: 8] = w_base + 8'(i);
            end
            c2h_tvalid   = 1'b1;
            c2h_tlast    = w_last;
            c2h_mty      = w_last ? w_mty_last : '0;
            c2h_ctrl_len = r_len;
            c2h_ctrl_qid = r_qid;
        end
        if (r_state == S_CMPT) begin
            cmpt_tvalid = 1'b1;
            cmpt_tdata  = CMPT_W'({r_pkt_idx, r_len, r_qid, 4'h1});
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign cfg_err  = r_cfg_err;
    assign pkt_sent = r_pkt_sent;

endmodule

// File: tb/tb_qdma_c2h_st_pkt_gen.sv
// Scoreboard bench for qdma_c2h_st_pkt_gen (DATA_W=512).
module tb_qdma_c2h_st_pkt_gen;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         stop = 1'b0;
    logic [11:0]  cfg_qid = '0;
    logic [15:0]  cfg_len = '0;
    logic [15:0]  cfg_num = '0;
    logic [511:0] c2h_tdata;
    logic         c2h_tvalid;
    logic         c2h_tready = 1'b1;
    logic         c2h_tlast;
    logic [5:0]   c2h_mty;
    logic [15:0]  c2h_ctrl_len;
    logic [11:0]  c2h_ctrl_qid;
    logic [127:0] cmpt_tdata;
    logic         cmpt_tvalid;
    logic         cmpt_tready = 1'b1;
    logic         busy;
    logic         done;
    logic         cfg_err;
    logic [15:0]  pkt_sent;

    int checks = 0;
    int errors = 0;
    bit rnd_rdy = 1'b0;

    typedef struct {
        logic [511:0] data;
        logic         last;
        logic [5:0]   mty;
        logic [15:0]  len;
        logic [11:0]  qid;
    } beat_t;

    beat_t        exp_q[$];
    logic [127:0] cq[$];

    qdma_c2h_st_pkt_gen dut (
        .axi_aclk(clk), .axi_aresetn(rst_n),
        .start(start), .stop(stop),
        .cfg_qid(cfg_qid), .cfg_len(cfg_len), .cfg_num(cfg_num),
        .c2h_tdata(c2h_tdata), .c2h_tvalid(c2h_tvalid),
        .c2h_tready(c2h_tready), .c2h_tlast(c2h_tlast),
        .c2h_mty(c2h_mty), .c2h_ctrl_len(c2h_ctrl_len),
        .c2h_ctrl_qid(c2h_ctrl_qid),
        .cmpt_tdata(cmpt_tdata), .cmpt_tvalid(cmpt_tvalid),
        .cmpt_tready(cmpt_tready),
        .busy(busy), .done(done), .cfg_err(cfg_err),
        .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        #1;
        c2h_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Expected beats: byte i of beat b = (idx + 64*b + i) mod 256.
    task automatic push_pkt(input int q, input int l, input int idx);
        int    beats;
        beat_t e;
        beats = (l + 63) / 64;
        for (int b = 0; b < beats; b++) begin
            for (int i = 0; i < 64; i++)
                e.data[8*i +: 8] = 8'((idx + b * 64 + i) % 256);
            e.last = (b == beats - 1);
            e.mty  = e.last ? 6'(beats * 64 - l) : 6'd0;
            e.len  = 16'(l);
            e.qid  = 12'(q);
            exp_q.push_back(e);
        end
        cq.push_back((128'(idx) << 32) | (128'(l) << 16) |
                     (128'(q) << 4) | 128'h1);
    endtask

    // Monitor: stall stability, exclusivity, and scoreboard pops.
    logic         st_d = 1'b0;
    logic         st_c = 1'b0;
    beat_t        sv_b;
    logic [127:0] sv_c;
    always @(negedge clk) begin
        beat_t        e;
        logic [127:0] c;
        if (!rst_n) begin
            st_d = 1'b0;
            st_c = 1'b0;
        end else begin
            if (c2h_tvalid || cmpt_tvalid)
                chk("valid_excl", {c2h_tvalid, cmpt_tvalid} == 2'b11, 0);
            if (st_d) begin
                checks++;
                if (!c2h_tvalid || c2h_tdata !== sv_b.data ||
                    c2h_tlast !== sv_b.last || c2h_mty !== sv_b.mty ||
                    c2h_ctrl_len !== sv_b.len || c2h_ctrl_qid !== sv_b.qid) begin
                    errors++;
                    $display("FAIL c2h_hold: v=%0b len=%0h mty=%0h got %0h expected %0h",
                             c2h_tvalid, c2h_ctrl_len, c2h_mty,
                             c2h_tdata[63:0], sv_b.data[63:0]);
                end
            end
            st_d = c2h_tvalid && !c2h_tready;
            sv_b = '{c2h_tdata, c2h_tlast, c2h_mty, c2h_ctrl_len, c2h_ctrl_qid};
            if (st_c) begin
                checks++;
                if (!cmpt_tvalid || cmpt_tdata !== sv_c) begin
                    errors++;
                    $display("FAIL cmpt_hold: v=%0b got %0h expected %0h",
                             cmpt_tvalid, cmpt_tdata, sv_c);
                end
            end
            st_c = cmpt_tvalid && !cmpt_tready;
            sv_c = cmpt_tdata;
            if (c2h_tvalid && c2h_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL c2h_unexpected: got %0h expected none",
                             c2h_tdata[63:0]);
                end else begin
                    e = exp_q.pop_front();
                    if (c2h_tdata !== e.data || c2h_tlast !== e.last ||
                        c2h_mty !== e.mty || c2h_ctrl_len !== e.len ||
                        c2h_ctrl_qid !== e.qid) begin
                        errors++;
                        $display("FAIL c2h_beat: got d=%0h l=%0b m=%0d len=%0d q=%0h expected d=%0h l=%0b m=%0d len=%0d q=%0h",
                                 c2h_tdata, c2h_tlast, c2h_mty, c2h_ctrl_len,
                                 c2h_ctrl_qid, e.data, e.last, e.mty, e.len, e.qid);
                    end
                end
            end
            if (cmpt_tvalid && cmpt_tready) begin
                checks++;
                if (cq.size() == 0) begin
                    errors++;
                    $display("FAIL cmpt_unexpected: got %0h expected none", cmpt_tdata);
                end else begin
                    c = cq.pop_front();
                    if (cmpt_tdata !== c) begin
                        errors++;
                        $display("FAIL cmpt_entry: got %0h expected %0h", cmpt_tdata, c);
                    end
                end
            end
        end
    end

    task automatic start_run(input int q, input int l, input int n);
        @(posedge clk);
        #1;
        cfg_qid = 12'(q);
        cfg_len = 16'(l);
        cfg_num = 16'(n);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("tvalid_after_start", c2h_tvalid, 1);
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_done(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
    endtask

    task automatic wait_cmpt_hs(input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (cmpt_tvalid && cmpt_tready) begin
                seen = 1'b1;
                break;
            end
        end
        chk("cmpt_hs_seen", seen, 1);
    endtask

    task automatic end_run(input int sent);
        chk("pkt_sent", pkt_sent, 128'(sent));
        chk("busy_idle", busy, 0);
        chk("c2h_drained", 128'(exp_q.size()), 0);
        chk("cmpt_drained", 128'(cq.size()), 0);
    endtask

    initial begin
        #3;
        chk("rst_tvalid", c2h_tvalid, 0);
        chk("rst_cmpt_tvalid", cmpt_tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_err", cfg_err, 0);
        chk("rst_pkt_sent", pkt_sent, 0);
        chk("rst_tdata", 128'(c2h_tdata != '0), 0);
        chk("rst_cmpt_tdata", cmpt_tdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // 1: len=100 -> 2 beats, mty 28, CMPT 0x64_0051
        push_pkt(5, 100, 0);
        start_run(5, 100, 1);
        chk("t1_ctrl_len", c2h_ctrl_len, 100);
        chk("t1_byte0", c2h_tdata[7:0], 8'h00);
        wait_cmpt_hs(20);
        chk("t1_cmpt_low", cmpt_tdata[47:0], 48'h0000_0064_0051);
        @(negedge clk);
        chk("t1_done_next", done, 1);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);
        end_run(1);

        // 2: single-beat packets
        for (int p = 0; p < 3; p++) push_pkt(2, 64, p);
        start_run(2, 64, 3);
        wait_done(100);
        end_run(3);

        // 3: random tready, CMPT stalled 10 cycles
        cmpt_tready = 1'b0;
        rnd_rdy = 1'b1;
        for (int p = 0; p < 3; p++) push_pkt(12'hABC, 150, p);
        start_run(12'hABC, 150, 3);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                if (cmpt_tvalid) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("t3_cmpt_seen", seen, 1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_no_next_pkt", {c2h_tvalid, cmpt_tvalid}, 2'b01);
        end
        @(posedge clk);
        #1;
        cmpt_tready = 1'b1;
        wait_done(2000);
        rnd_rdy = 1'b0;
        end_run(3);

        // 4: stop raised during packet 1
        push_pkt(7, 100, 0);
        push_pkt(7, 100, 1);
        start_run(7, 100, 10);
        wait_cmpt_hs(20);
        @(posedge clk);
        #1;
        stop = 1'b1;
        wait_done(50);
        stop = 1'b0;
        end_run(2);
        repeat (5) @(negedge clk);
        chk("t4_no_third", c2h_tvalid, 0);

        // 5: rejected configs, then start while busy
        for (int v = 0; v < 2; v++) begin
            @(posedge clk);
            #1;
            cfg_len = (v == 0) ? 16'd0 : 16'd64;
            cfg_num = (v == 0) ? 16'd3 : 16'd0;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("t5_cfg_err", cfg_err, 1);
            chk("t5_busy", busy, 0);
            @(negedge clk);
            chk("t5_cfg_err_pulse", cfg_err, 0);
        end
        push_pkt(4, 64, 0);
        push_pkt(4, 64, 1);
        start_run(4, 64, 2);
        @(posedge clk);
        #1;
        cfg_qid = 12'h1;
        cfg_len = 16'd8;
        cfg_num = 16'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(50);
        end_run(2);

        // 6: reset mid-packet drops it
        push_pkt(9, 200, 0);
        start_run(9, 200, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_tvalid_rst", c2h_tvalid, 0);
        chk("t6_busy_rst", busy, 0);
        chk("t6_cmpt_rst", cmpt_tvalid, 0);
        exp_q.delete();
        cq.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_pkt(3, 64, 0);
        start_run(3, 64, 1);
        chk("t6_byte0", c2h_tdata[7:0], 8'h00);
        wait_done(50);
        end_run(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
